// File: rtl/updown_count_display.sv
// updown_count_display: extends a 4-bit up/down count to 8 bits by tracking wraps.
// It also flags carry, borrow and illegal steps, and drives a 2-digit multiplexed hex display.
module updown_count_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic [3:0]       q_in,
   input  logic             down_in,
   output logic [7:0]       ext_count,
   output logic             carry,
   output logic             borrow,
   output logic             step_err,
   output logic [1:0]       an,
   output logic [6:0]       seg
);
   localparam logic [6:0] HEX7 [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   logic [3:0]       q_prev;
   logic [3:0]       hi_next;
   logic [3:0]       nib;
   logic [CNT_W-1:0] prescaler;
   logic             digit_sel;
   logic             up_wrap;
   logic             dn_wrap;
   logic             legal;
   logic             last;
   // hi lives in ext_count[7:4]; it always equals the tracked upper nibble
   always_comb begin
      up_wrap = q_prev == 4'hF && q_in == 4'h0 && !down_in;
      dn_wrap = q_prev == 4'h0 && q_in == 4'hF && down_in;
      legal   = (q_in == q_prev) ||
                (!down_in && q_in == q_prev + 4'd1) ||
                (down_in && q_in == q_prev - 4'd1);
      hi_next = up_wrap ? ext_count[7:4] + 4'd1 :
                dn_wrap ? ext_count[7:4] - 4'd1 : ext_count[7:4];
      last    = prescaler == CNT_W'(REFRESH_DIV - 1);
      nib     = digit_sel ? ext_count[7:4] : ext_count[3:0];
   end
   always_ff @(posedge clock) begin
      if (Reset) begin
         q_prev    <= 4'h0;
         ext_count <= 8'h00;
         carry     <= 1'b0;
         borrow    <= 1'b0;
         step_err  <= 1'b0;
      end else begin
         q_prev    <= q_in;
         ext_count <= {hi_next, q_in};
         carry     <= up_wrap;
         borrow    <= dn_wrap;
         step_err  <= step_err | ~legal;
      end
   end
   // display refresh: outputs follow the digit selected before this edge
   always_ff @(posedge clock) begin
      if (Reset) begin
         prescaler <= '0;
         digit_sel <= 1'b0;
         an        <= 2'b10;
         seg       <= 7'b1000000;
      end else begin
         prescaler <= last ? '0 : prescaler + CNT_W'(1);
         digit_sel <= digit_sel ^ last;
         an        <= digit_sel ? 2'b01 : 2'b10;
         seg       <= HEX7[nib];
      end
   end
endmodule

// File: tb/tb_updown_count_display.sv
// tb_updown_count_display: directed stimulus with an arithmetic reference model
// checked every cycle, plus literal expectations taken from the worked examples.
module tb_updown_count_display;
   localparam int DIV = 4;
   logic       clock = 0;
   logic       Reset = 0;
   logic [3:0] q_in = 0;
   logic       down_in = 0;
   logic [7:0] ext_count;
   logic       carry, borrow, step_err;
   logic [1:0] an;
   logic [6:0] seg;
   int passed = 0, total = 0;
   bit chk_en = 0;
   int hexs [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                     7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                     7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   int m_prev, m_val, m_carry, m_borrow, m_err, m_n, m_an, m_seg;

   updown_count_display #(.REFRESH_DIV(DIV), .CNT_W(4)) dut (
      .clock(clock), .Reset(Reset), .q_in(q_in), .down_in(down_in),
      .ext_count(ext_count), .carry(carry), .borrow(borrow),
      .step_err(step_err), .an(an), .seg(seg));

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // reference model: the extended count is a mod-256 number moved by legal steps
   always @(posedge clock) begin
      if (Reset) begin
         m_prev = 0; m_val = 0; m_carry = 0; m_borrow = 0; m_err = 0;
         m_n = 0; m_an = 2; m_seg = hexs[0];
      end else begin
         int diff;
         m_an  = ((m_n / DIV) % 2) ? 1 : 2;
         m_seg = ((m_n / DIV) % 2) ? hexs[m_val / 16] : hexs[m_val % 16];
         m_n++;
         diff = (int'(q_in) - m_prev + 16) % 16;
         m_carry = 0; m_borrow = 0;
         if (diff == 0) ;
         else if (!down_in && diff == 1) begin
            m_val = (m_val + 1) % 256; m_carry = (q_in == 0);
         end else if (down_in && diff == 15) begin
            m_val = (m_val + 255) % 256; m_borrow = (q_in == 15);
         end else begin
            m_val = (m_val / 16) * 16 + int'(q_in); m_err = 1;
         end
         m_prev = int'(q_in);
      end
   end

   always @(negedge clock) if (chk_en) begin
      chk("ext_count", int'(ext_count), m_val);
      chk("carry", int'(carry), m_carry);
      chk("borrow", int'(borrow), m_borrow);
      chk("step_err", int'(step_err), m_err);
      chk("an", int'(an), m_an);
      chk("seg", int'(seg), m_seg);
   end

   task automatic drive(input int q, input bit d);
      q_in = 4'(q); down_in = d;
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      Reset = 1; q_in = 0; down_in = 0;
      @(posedge clock); #1;
      Reset = 0; chk_en = 1;
   endtask

   initial begin
      #2;
      do_reset();
      chk("rst_ext", int'(ext_count), 8'h00);
      chk("rst_an", int'(an), 2'b10);
      chk("rst_seg", int'(seg), 7'b1000000);
      chk("rst_err", int'(step_err), 0);
      // count up through a wrap
      drive(0, 0);
      for (int i = 1; i < 16; i++) drive(i, 0);
      chk("up_0F", int'(ext_count), 8'h0F);
      drive(0, 0);
      chk("up_wrap_ext", int'(ext_count), 8'h10);
      chk("up_wrap_carry", int'(carry), 1);
      drive(1, 0);
      chk("up_11", int'(ext_count), 8'h11);
      chk("up_carry_gone", int'(carry), 0);
      chk("up_no_err", int'(step_err), 0);
      // down-wrap from zero
      do_reset();
      drive(0, 1);
      drive(15, 1);
      chk("dn_FF", int'(ext_count), 8'hFF);
      chk("dn_borrow", int'(borrow), 1);
      drive(14, 1);
      chk("dn_FE", int'(ext_count), 8'hFE);
      chk("dn_borrow_gone", int'(borrow), 0);
      // reverse direction above a wrap
      do_reset();
      for (int i = 1; i <= 18; i++) drive(i % 16, 0);
      chk("rev_12", int'(ext_count), 8'h12);
      drive(1, 1);
      chk("rev_11", int'(ext_count), 8'h11);
      drive(0, 1);
      chk("rev_10", int'(ext_count), 8'h10);
      drive(15, 1);
      chk("rev_0F", int'(ext_count), 8'h0F);
      chk("rev_borrow", int'(borrow), 1);
      chk("rev_no_err", int'(step_err), 0);
      // illegal jump, sticky error, then cleared by reset
      do_reset();
      for (int i = 1; i <= 3; i++) drive(i, 0);
      drive(7, 0);
      chk("jump_ext", int'(ext_count), 8'h07);
      chk("jump_err", int'(step_err), 1);
      drive(8, 0); drive(9, 0);
      chk("sticky_err", int'(step_err), 1);
      drive(10, 1);
      chk("wrongdir_ext", int'(ext_count), 8'h0A);
      do_reset();
      chk("err_cleared", int'(step_err), 0);
      // display of A5
      for (int i = 1; i <= 165; i++) drive(i % 16, 0);
      chk("disp_ext", int'(ext_count), 8'hA5);
      for (int i = 0; i < 3 * DIV; i++) begin
         drive(5, 0);
         if (an == 2'b10) chk("disp_lo_seg", int'(seg), 7'b0010010);
         else begin
            chk("disp_an", int'(an), 2'b01);
            chk("disp_hi_seg", int'(seg), 7'b0001000);
         end
      end
      // reset mid-dwell at 3C
      do_reset();
      for (int i = 1; i <= 60; i++) drive(i % 16, 0);
      drive(12, 0); drive(12, 0);
      chk("pre_rst_ext", int'(ext_count), 8'h3C);
      do_reset();
      chk("mid_rst_ext", int'(ext_count), 8'h00);
      chk("mid_rst_carry", int'(carry), 0);
      chk("mid_rst_borrow", int'(borrow), 0);
      chk("mid_rst_an", int'(an), 2'b10);
      chk("mid_rst_seg", int'(seg), 7'b1000000);
      for (int i = 0; i < 2 * DIV + 2; i++) drive(0, 0);
      @(negedge clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
